// File: rtl/bcd_pkg.sv
// bcd_pkg: constants, state type and arithmetic helper shared by
// the BCD entry and display paths.
package bcd_pkg;

  localparam int BCD_NDIG = 8;
  localparam int BCD_W    = 28;

  // Blanking code: a malformed entry shows as a blank display.
  localparam logic [BCD_W-1:0] BCD_BLANK = 28'h7FFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } bcd_state_t;

  function automatic logic [BCD_W-1:0] mul10(
    input logic [BCD_W-1:0] x
  );
    return (x << 3) + (x << 1);
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: request/result bundle between the entry logic and
// the BCD-to-binary converter.
interface bcd_to_bin_if
  import bcd_pkg::*;
#(
  parameter int NDIG = BCD_NDIG,
  parameter int W    = BCD_W
);

  logic              start;
  logic [4*NDIG-1:0] bcd_in;
  logic [W-1:0]      result;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start,
    output bcd_in,
    input  result,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  bcd_in,
    output result,
    output busy,
    output done,
    output error
  );

endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to binary converter, one digit
// per clock, MSD first (acc = acc*10 + digit).
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG = BCD_NDIG,
  parameter int W    = BCD_W
) (
  input logic         clk,
  input logic         rst_n,
  bcd_to_bin_if.slave bus
);

  localparam int CW = $clog2(NDIG);

  bcd_state_t state;
  bcd_state_t state_nxt;

  logic [4*NDIG-1:0] sreg;
  logic [W-1:0]      acc;
  logic [CW-1:0]     cnt;
  logic              err;
  logic [3:0]        dig;

  logic load;
  logic step;
  logic fin;

  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         error;

  assign dig = sreg[4*NDIG-1 -: 4];

  assign bus.result = result;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.error  = error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start) state_nxt = CONV;
      CONV: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    unique case (1'b1)
      state == IDLE: load = bus.start;
      state == CONV: step = 1'b1;
      state == DONE: fin  = 1'b1;
      default: ;
    endcase
  end

  // Result and error only move at the DONE edge; busy/done registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      acc    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        sreg <= bus.bcd_in;
        acc  <= '0;
        err  <= 1'b0;
        cnt  <= CW'(NDIG - 1);
        busy <= 1'b1;
      end
      if (step) begin
        acc  <= mul10(acc) + W'(dig);
        err  <= err | (dig > 4'd9);
        sreg <= sreg << 4;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (fin) begin
        result <= err ? BCD_BLANK : acc;
        error  <= err;
        busy   <= 1'b0;
      end
    end
  end

endmodule
